// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router.
package rom_dl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    ISSUE    = 2'd2,
    WAIT_ACK = 2'd3
  } dl_state_e;

  localparam logic REG_MODE_LINEAR16 = 1'b0;
  localparam logic REG_MODE_IL32     = 1'b1;

  // Width of a target index: up to 4 SDRAM ports plus the BRAM bus.
  localparam int PI_W  = 3;
  localparam int REG_W = 3;

endpackage

// File: rtl/dl_region_decode.sv
// Combinational address decoder: byte address -> region hit, target port, packing mode, offset.
module dl_region_decode
  import rom_dl_pkg::*;
#(
  parameter int          NUM_REGIONS = 4,
  parameter int          ADDR_W      = 25,
  parameter int unsigned REG_BASE [NUM_REGIONS] = '{32'h00000, 32'h10000, 32'h1C000, 32'h0F000},
  parameter int unsigned REG_END  [NUM_REGIONS] = '{32'h0FFFF, 32'h1BFFF, 32'h1DFFF, 32'h0FFFF},
  parameter int unsigned REG_PORT [NUM_REGIONS] = '{0, 1, 2, 1},
  parameter int unsigned REG_MODE [NUM_REGIONS] = '{0, 1, 0, 0}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [REG_W-1:0]  region,
  output logic [PI_W-1:0]   port,
  output logic              mode,
  output logic [ADDR_W-1:0] offset
);

  // Scan from the top down so the lowest-numbered matching region overrides.
  always_comb begin
    hit    = 1'b0;
    region = '0;
    port   = '0;
    mode   = REG_MODE_LINEAR16;
    offset = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((32'(addr) >= REG_BASE[i]) && (32'(addr) <= REG_END[i])) begin
        hit    = 1'b1;
        region = REG_W'(i);
        port   = PI_W'(REG_PORT[i]);
        mode   = (REG_MODE[i] == 1) ? REG_MODE_IL32 : REG_MODE_LINEAR16;
        offset = addr - ADDR_W'(REG_BASE[i]);
      end
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// Routes hps_io ioctl download bytes to toggle-handshake SDRAM ports or the BRAM dl_* bus,
// and produces rom_loaded plus a stretched core reset.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          NUM_REGIONS = 4,
  parameter int          ADDR_W      = 25,
  parameter int          PA_W        = 23,
  parameter int unsigned REG_BASE [NUM_REGIONS] = '{32'h00000, 32'h10000, 32'h1C000, 32'h0F000},
  parameter int unsigned REG_END  [NUM_REGIONS] = '{32'h0FFFF, 32'h1BFFF, 32'h1DFFF, 32'h0FFFF},
  parameter int unsigned REG_PORT [NUM_REGIONS] = '{0, 1, 2, 1},
  parameter int unsigned REG_MODE [NUM_REGIONS] = '{0, 1, 0, 0},
  parameter int          IL_BIT      = 14,
  parameter int          DL_INDEX    = 0,
  parameter int          RST_CYCLES  = 65535
) (
  input  logic                      clk_mem,
  input  logic                      reset_n,
  input  logic                      ioctl_download,
  input  logic                      ioctl_wr,
  input  logic [ADDR_W-1:0]         ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic [7:0]                ioctl_index,
  output logic                      ioctl_wait,
  output logic [NUM_PORTS-1:0]      port_req,
  input  logic [NUM_PORTS-1:0]      port_ack,
  output logic [NUM_PORTS*PA_W-1:0] port_a,
  output logic [NUM_PORTS*2-1:0]    port_ds,
  output logic [NUM_PORTS*16-1:0]   port_d,
  output logic                      port_we,
  output logic [ADDR_W-1:0]         dl_addr,
  output logic [7:0]                dl_data,
  output logic                      dl_wr,
  input  logic                      reset_req,
  output logic                      rom_loaded,
  output logic                      core_reset,
  output logic [1:0]                dbg_state,
  output logic [REG_W-1:0]          dbg_region
);

  localparam int CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  // Handshake: a port has a write outstanding while port_req != port_ack. The router
  // toggles port_req once per word and the memory side toggles port_ack to match when done.

  dl_state_e             state;
  logic                  wr_q;
  logic                  dl_q;
  logic                  fall_pend;
  logic [ADDR_W-1:0]     addr_q;
  logic [7:0]            data_q;
  logic [PI_W-1:0]       port_q;
  logic [REG_W-1:0]      region_q;
  logic [PA_W-1:0]       a_q;
  logic [1:0]            ds_q;
  logic [NUM_PORTS-1:0]  req_q;
  logic [PA_W-1:0]       pa_q  [NUM_PORTS];
  logic [1:0]            pds_q [NUM_PORTS];
  logic [15:0]           pd_q  [NUM_PORTS];
  logic [CNT_W-1:0]      cnt_q;

  logic                  dec_hit;
  logic [REG_W-1:0]      dec_region;
  logic [PI_W-1:0]       dec_port;
  logic                  dec_mode;
  logic [ADDR_W-1:0]     dec_off;
  logic [NUM_PORTS-1:0]  tgt_sel;
  logic                  tgt_busy;
  logic                  tgt_bram;
  logic                  wr_rise;

  dl_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REG_BASE    (REG_BASE),
    .REG_END     (REG_END),
    .REG_PORT    (REG_PORT),
    .REG_MODE    (REG_MODE)
  ) u_decode (
    .addr   (addr_q),
    .hit    (dec_hit),
    .region (dec_region),
    .port   (dec_port),
    .mode   (dec_mode),
    .offset (dec_off)
  );

  always_comb begin
    tgt_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) tgt_sel[p] = (port_q == PI_W'(p));
  end

  assign tgt_bram = (port_q >= PI_W'(NUM_PORTS));
  assign tgt_busy = |((req_q ^ port_ack) & tgt_sel);
  assign wr_rise  = ioctl_wr & ~wr_q;

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      port_q     <= '0;
      region_q   <= '0;
      a_q        <= '0;
      ds_q       <= '0;
      req_q      <= port_ack;
      ioctl_wait <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      dl_wr      <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pa_q[p]  <= '0;
        pds_q[p] <= '0;
        pd_q[p]  <= '0;
      end
    end else begin
      wr_q  <= ioctl_wr;
      dl_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_rise && ioctl_download && (ioctl_index == 8'(DL_INDEX))) begin
            addr_q     <= ioctl_addr;
            data_q     <= ioctl_dout;
            ioctl_wait <= 1'b1;
            state      <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_hit) begin
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else begin
            port_q   <= dec_port;
            region_q <= dec_region;
            if (dec_mode == REG_MODE_IL32) begin
              // The IL_BIT half-select becomes the byte lane; IL_BIT+1 becomes word bit 0.
              a_q  <= PA_W'({dec_off[PA_W+1:IL_BIT+2], dec_off[IL_BIT-1:0], dec_off[IL_BIT+1]});
              ds_q <= {dec_off[IL_BIT], ~dec_off[IL_BIT]};
            end else begin
              a_q  <= dec_off[PA_W:1];
              ds_q <= {dec_off[0], ~dec_off[0]};
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (tgt_bram) begin
            dl_addr    <= addr_q;
            dl_data    <= data_q;
            dl_wr      <= 1'b1;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else if (!tgt_busy) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (tgt_sel[p]) begin
                pa_q[p]  <= a_q;
                pds_q[p] <= ds_q;
                pd_q[p]  <= {data_q, data_q};
                req_q[p] <= ~req_q[p];
              end
            end
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!tgt_busy) begin
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rom_loaded waits for any in-flight write to finish after download drops.
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      fall_pend  <= 1'b0;
      rom_loaded <= 1'b0;
      port_we    <= 1'b0;
      cnt_q      <= CNT_W'(RST_CYCLES);
    end else begin
      dl_q    <= ioctl_download;
      port_we <= ioctl_download;
      if (dl_q && !ioctl_download) begin
        fall_pend <= 1'b1;
      end else if (fall_pend && (state == IDLE)) begin
        fall_pend  <= 1'b0;
        rom_loaded <= 1'b1;
      end
      if (reset_req || !rom_loaded) cnt_q <= CNT_W'(RST_CYCLES);
      else if (cnt_q != '0)         cnt_q <= cnt_q - 1'b1;
    end
  end

  assign core_reset = ~rom_loaded | reset_req | (cnt_q != '0);
  assign port_req   = req_q;
  assign dbg_state  = state;
  assign dbg_region = region_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_a[p*PA_W +: PA_W] = pa_q[p];
    assign port_ds[p*2 +: 2]      = pds_q[p];
    assign port_d[p*16 +: 16]     = pd_q[p];
  end

endmodule
